// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared FSM state type and default sizes for the register write arbiter
package reg_write_arbiter_pkg;

  localparam int DEFAULT_NREQ = 4;
  localparam int DEFAULT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/reg_write_arbiter_register_wb.sv
// rtl/reg_write_arbiter_register_wb.sv - shared register with synchronous clear and write enable
module reg_write_arbiter_register_wb
  import reg_write_arbiter_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Storage: async power-on reset, then sync clear has priority over a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (rst) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter granting single writes into one shared register
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int W    = DEFAULT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  input  logic              clr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [W-1:0]      q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic            load_grant;
  logic            reg_en;
  logic            reg_clr;
  logic [W-1:0]    reg_d;

  // Round-robin search: first asserted request at ptr, ptr+1, ... wrapping at NREQ
  always_comb begin
    int j;
    j         = 0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (!win_valid && req[j]) begin
        win_valid = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  // Grant, winner index and pointer only change on the IDLE->WRITE edge; grant drops otherwise
  always_comb begin
    load_grant = (state_q == ST_IDLE) && !clr && win_valid;
    gnt_d      = '0;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    if (load_grant) begin
      gnt_d[win_idx] = 1'b1;
      idx_d          = win_idx;
      ptr_d          = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  // Grant / pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: clear beats any request; WRITE and CLEAR last one cycle
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
        end else if (win_valid) begin
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: write data comes from the granted slot as presented during WRITE
  always_comb begin
    busy    = (state_q != ST_IDLE);
    ack     = '0;
    reg_en  = 1'b0;
    reg_clr = 1'b0;
    reg_d   = wdata[int'(idx_q)*W +: W];
    case (state_q)
      ST_WRITE: begin
        ack    = gnt_q;
        reg_en = 1'b1;
      end
      ST_CLEAR: reg_clr = 1'b1;
      default: ;
    endcase
  end

  assign gnt = gnt_q;

  reg_write_arbiter_register_wb #(
    .W(W)
  ) register_wb (
    .clk  (clk),
    .rst_n(rst_n),
    .rst  (reg_clr),
    .en   (reg_en),
    .d    (reg_d),
    .q    (q)
  );

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning: number of requesters (2..8).
REQ-002 Parameter W, default 8, meaning: data width of the shared register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester write request, level, held until ack.
REQ-006 wdata  input  NREQ*W  packed write data, requester i at bits [i*W +: W].
REQ-007 clr  input  1  synchronous clear request for the shared register.
REQ-008 gnt  output  NREQ  registered one-hot grant, all zero when no write is in progress.
REQ-009 ack  output  NREQ  one-cycle pulse to the requester whose data is written this cycle.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 q  output  W  current contents of the shared register.

Function
REQ-012 FSM states: IDLE, WRITE, CLEAR, encoded in 2 bits.
REQ-013 IDLE -> CLEAR when clr=1, regardless of req (clr has priority over all requesters).
REQ-014 IDLE -> WRITE when clr=0 and req!=0; gnt loads the round-robin winner on that edge.
REQ-015 IDLE -> IDLE when clr=0 and req=0; gnt stays 0.
REQ-016 WRITE: register enable=1, d=wdata of granted index; ack=gnt for this cycle only; q shows the new value from the next edge.
REQ-017 WRITE -> IDLE unconditionally; gnt clears on that edge; each write therefore occupies 2 cycles (arbitrate, write).
REQ-018 CLEAR: register synchronously reset to 0; ack=0; CLEAR -> IDLE unconditionally.
REQ-019 Round-robin: a priority pointer ptr (clog2(NREQ) bits) names the highest-priority index; the winner is the first asserted req at ptr, ptr+1, ... modulo NREQ.
REQ-020 ptr updates to (winner+1) mod NREQ on the IDLE->WRITE edge only; wrap from NREQ-1 to 0.
REQ-021 req changes during WRITE or CLEAR are ignored; data is sampled only in WRITE from the granted slot.
REQ-022 Withdrawal of a granted req before its ack does not cancel the write; the write completes with the wdata presented in WRITE.
REQ-023 Requester deasserting req the cycle after ack is required; a req still high in the following IDLE is treated as a new request.
REQ-024 gnt and ack are one-hot or zero at all times; ack is never asserted outside WRITE.
REQ-025 q holds its value in IDLE and in WRITE's cycle until the capturing edge; no other path modifies q.

Reset
REQ-026 rst_n=0 forces state=IDLE, gnt=0, ptr=0, q=0 immediately, independent of clk.
REQ-027 Reset asserted during WRITE aborts the write: no ack is issued after reset release and q=0.
REQ-028 After rst_n rises, the first arbitration occurs on the first rising edge with req!=0.

Structure
REQ-029 A shared package holds the FSM state enum (IDLE, WRITE, CLEAR) and the default NREQ/W constants.
REQ-030 The shared register is one sub-module instance, register_wb, with clk, sync rst, en, d, q; its rst is driven by (CLEAR state) and its storage reset asynchronously by rst_n.
REQ-031 Round-robin selection is combinational logic inside reg_write_arbiter; no other sub-modules.

Verification
REQ-032 Reset then idle: rst_n=0 -> q=00, gnt=0000, busy=0; req=0 for 3 cycles -> unchanged.
REQ-033 Single write: req=0001, wdata0=A5 -> gnt=0001 at cycle 1, ack=0001 at cycle 1, q=A5 at cycle 2, busy back to 0.
REQ-034 Fairness: req=1111 held, wdata{3..0}={44,33,22,11}, each requester drops req after its ack -> grants in order 0,1,2,3; final q=44.
REQ-035 Wrap-around: ptr=3 after a write by 2, req=1001 -> requester 3 wins, then requester 0; q sequence as supplied.
REQ-036 Clear priority: q=5A, clr=1 with req=0010 in IDLE -> CLEAR first, q=00, then requester 1 granted next arbitration.
REQ-037 Reset mid-write: rst_n=0 during WRITE for requester 2 with wdata2=FF -> q=00, ack=0000, gnt=0000 after release.
